// File: rtl/mmap_timer.sv
// mmap_timer: memory-mapped down-counting timer with prescaler, auto-reload and interrupt
module mmap_timer (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [127:0] mem_wd,
  output logic [127:0] mem_rd,
  output logic         irq
);
  localparam logic [31:0] CTRL_MASK = 32'h0000_FF07;
  logic [31:0] r_ctrl, r_load, r_count;
  logic        r_exp, r_irq;
  logic [7:0]  r_psc;
  logic        w_ctrl_wr, w_count_wr, w_tick, w_expire, w_exp_nx, w_unused;
  logic [31:0] w_ctrl_nx, w_count_nx;
  logic [7:0]  w_psc_nx;
  assign mem_rd = {31'b0, r_exp, r_count, r_load, r_ctrl};
  assign irq    = r_irq;
  assign w_unused = &{1'b0, mem_wd[127:97]};
  // A word counts as written only when the mapper presents a different value
  assign w_ctrl_wr  = mem_wd[31:0] != r_ctrl;
  assign w_count_wr = mem_wd[95:64] != r_count;
  assign w_tick     = r_ctrl[0] && r_psc == r_ctrl[15:8];
  // A software COUNT write on a tick suppresses both decrement and expiry
  assign w_expire   = w_tick && r_count == 32'd0 && !w_count_wr;
  // One-shot expiry drops EN unless software rewrote CTRL in the same cycle
  assign w_ctrl_nx  = (mem_wd[31:0] & CTRL_MASK) & ~{31'b0, w_expire & ~r_ctrl[1] & ~w_ctrl_wr};
  // Reload takes the incoming LOAD so a same-cycle LOAD write is honoured
  assign w_count_nx = w_count_wr ? mem_wd[95:64] :
                      !w_tick ? r_count :
                      r_count != 32'd0 ? r_count - 32'd1 :
                      r_ctrl[1] ? mem_wd[63:32] : 32'd0;
  assign w_exp_nx   = w_expire | mem_wd[96];
  assign w_psc_nx   = (!r_ctrl[0] || w_ctrl_wr || w_tick) ? 8'd0 : r_psc + 8'd1;
  // Register file, prescaler and interrupt flop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ctrl  <= '0;
      r_load  <= '0;
      r_count <= '0;
      r_exp   <= 1'b0;
      r_psc   <= '0;
      r_irq   <= 1'b0;
    end else begin
      r_ctrl  <= w_ctrl_nx;
      r_load  <= mem_wd[63:32];
      r_count <= w_count_nx;
      r_exp   <= w_exp_nx;
      r_psc   <= w_psc_nx;
      r_irq   <= w_exp_nx & w_ctrl_nx[2];
    end
  end
endmodule

// File: tb/tb_mmap_timer.sv
// tb_mmap_timer: directed vector table, randomized model comparison and async reset check
module tb_mmap_timer;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [127:0] mem_wd = '0;
  logic [127:0] mem_rd;
  logic         irq;
  int n_tests = 0;
  int n_fail = 0;
  logic [31:0] m_w [4];
  logic [7:0]  m_psc;
  logic        m_irq;

  typedef struct {
    bit          wr;
    int          idx;
    logic [31:0] d;
    logic [31:0] c, l, k, s;
    bit          q;
  } vec_t;
  vec_t tv[$];

  mmap_timer dut (.clk(clk), .rst_n(rst_n), .mem_wd(mem_wd), .mem_rd(mem_rd), .irq(irq));

  always #5 clk = ~clk;

  function automatic logic [127:0] mrd();
    return {m_w[3], m_w[2], m_w[1], m_w[0]};
  endfunction

  task automatic check(input string n, input logic [127:0] a, input logic [127:0] e);
    n_tests++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_w[i] = '0;
    m_psc = '0;
    m_irq = 1'b0;
  endtask

  task automatic model(input logic [127:0] wd);
    bit cw, kw, en, ar, tick, ev;
    logic [31:0] nc, nk;
    cw = wd[31:0] != m_w[0];
    kw = wd[95:64] != m_w[2];
    en = m_w[0][0];
    ar = m_w[0][1];
    tick = en && m_psc == m_w[0][15:8];
    ev = tick && m_w[2] == 0 && !kw;
    nc = wd[31:0] & 32'h0000_FF07;
    if (ev && !ar && !cw) nc[0] = 1'b0;
    if (kw) nk = wd[95:64];
    else if (!tick) nk = m_w[2];
    else if (m_w[2] != 0) nk = m_w[2] - 1;
    else nk = ar ? wd[63:32] : 32'd0;
    m_psc = (!en || cw || tick) ? 8'd0 : m_psc + 8'd1;
    m_w[0] = nc;
    m_w[1] = wd[63:32];
    m_w[2] = nk;
    m_w[3] = {31'b0, ev | wd[96]};
    m_irq = m_w[3][0] & nc[2];
  endtask

  task automatic step(input bit wr, input int idx, input logic [31:0] d);
    logic [127:0] wd;
    wd = mrd();
    if (wr) wd[idx*32 +: 32] = d;
    mem_wd = wd;
    @(posedge clk);
    model(wd);
    #1;
    check("model_rd", mem_rd, mrd());
    check("model_irq", {127'b0, irq}, {127'b0, m_irq});
  endtask

  task automatic add(input bit wr, input int idx, input logic [31:0] d,
                     input logic [31:0] c, input logic [31:0] l, input logic [31:0] k,
                     input logic [31:0] s, input bit q);
    vec_t v;
    v.wr = wr; v.idx = idx; v.d = d; v.c = c; v.l = l; v.k = k; v.s = s; v.q = q;
    tv.push_back(v);
  endtask

  initial begin
    model_reset();
    // one-shot
    add(1, 2, 3, 0, 0, 3, 0, 0);
    add(1, 0, 1, 1, 0, 3, 0, 0);
    add(0, 0, 0, 1, 0, 2, 0, 0);
    add(0, 0, 0, 1, 0, 1, 0, 0);
    add(0, 0, 0, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 1, 0);
    // reserved bits, EXP clear
    add(1, 0, 32'hFFFF_FFFF, 32'hFF07, 0, 0, 1, 1);
    add(1, 3, 0, 32'hFF07, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0, 0);
    // auto-reload
    add(1, 1, 2, 0, 2, 0, 0, 0);
    add(1, 0, 7, 7, 2, 0, 0, 0);
    add(0, 0, 0, 7, 2, 2, 1, 1);
    add(0, 0, 0, 7, 2, 1, 1, 1);
    add(0, 0, 0, 7, 2, 0, 1, 1);
    add(0, 0, 0, 7, 2, 2, 1, 1);
    // collisions
    add(1, 2, 32'h100, 7, 2, 32'h100, 1, 1);
    add(1, 3, 0, 7, 2, 32'hFF, 0, 0);
    add(1, 2, 0, 7, 2, 0, 0, 0);
    add(0, 0, 0, 7, 2, 2, 1, 1);
    add(0, 0, 0, 7, 2, 1, 1, 1);
    add(0, 0, 0, 7, 2, 0, 1, 1);
    add(1, 3, 0, 7, 2, 2, 1, 1);
    add(1, 0, 0, 0, 2, 1, 1, 0);
    // prescale
    add(1, 2, 5, 0, 2, 5, 1, 0);
    add(1, 0, 32'h301, 32'h301, 2, 5, 1, 0);
    add(0, 0, 0, 32'h301, 2, 5, 1, 0);
    add(0, 0, 0, 32'h301, 2, 5, 1, 0);
    add(0, 0, 0, 32'h301, 2, 5, 1, 0);
    add(0, 0, 0, 32'h301, 2, 4, 1, 0);
    // software CTRL write wins over one-shot EN clear
    add(1, 0, 1, 1, 2, 4, 1, 0);
    add(1, 2, 0, 1, 2, 0, 1, 0);
    add(1, 0, 5, 5, 2, 0, 1, 1);
    add(0, 0, 0, 4, 2, 0, 1, 1);

    #2;
    check("reset_rd", mem_rd, 128'd0);
    check("reset_irq", {127'b0, irq}, 128'd0);
    #10 rst_n = 1'b1;

    foreach (tv[i]) begin
      step(tv[i].wr, tv[i].idx, tv[i].d);
      check($sformatf("vec%0d", i), mem_rd, {tv[i].s, tv[i].k, tv[i].l, tv[i].c});
      check($sformatf("vec%0d_irq", i), {127'b0, irq}, {127'b0, tv[i].q});
    end

    for (int i = 0; i < 400; i++) begin
      int idx;
      logic [31:0] d;
      idx = $urandom_range(0, 3);
      d = $urandom;
      if (idx == 0) d = d & 32'hFFFF_03FF;
      if (idx == 1 || idx == 2) d = $urandom_range(0, 6);
      step($urandom_range(0, 2) == 0, idx, d);
    end

    step(1, 0, 0);
    step(1, 3, 0);
    step(1, 2, 50);
    step(1, 0, 32'h5);
    for (int i = 0; i < 3; i++) step(0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_rd", mem_rd, 128'd0);
    check("async_rst_irq", {127'b0, irq}, 128'd0);
    model_reset();
    #1 rst_n = 1'b1;
    for (int i = 0; i < 60; i++) step(0, 0, 0);
    check("no_exp_after_rst", {127'b0, mem_rd[96]}, 128'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mmap_timer.md
MMAP_TIMER -- requirements
Module: mmap_timer

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port mem_rd, output, 128 bits: current register contents, word i at bits [32*i+31:32*i], driven directly from flops.
REQ-004 SHALL have port mem_wd, input, 128 bits: next-word vector from the bus-side word mapper, equal to mem_rd except the word being written.
REQ-005 SHALL have port irq, output, 1 bit: interrupt request, equal to STATUS.EXP AND CTRL.IE, from flops with no combinational path from mem_wd.
REQ-006 SHALL have no parameters; the word count is fixed at 4.

Function
REQ-007 SHALL implement these word map entries: word 0 CTRL (bit0 EN, bit1 AR auto-reload, bit2 IE, bits[15:8] PRESC), word 1 LOAD[31:0], word 2 COUNT[31:0], word 3 STATUS (bit0 EXP).
REQ-008 SHALL return 0 on reads of reserved bits (CTRL[7:3], CTRL[31:16], STATUS[31:1]) and SHALL ignore writes to them.
REQ-009 SHALL treat a word as software-written in a cycle when its mem_wd value differs from its mem_rd value; rewriting an identical value is indistinguishable from no write.
REQ-010 SHALL load every word with its mem_wd value each cycle, after masking reserved bits, except where REQ-013 to REQ-018 override it.
REQ-011 SHALL keep an 8-bit prescale counter; while CTRL.EN=1 it counts 0..PRESC and asserts an internal tick in the cycle it equals PRESC, then wraps to 0.
REQ-012 SHALL clear the prescale counter to 0 in any cycle where CTRL.EN=0 or CTRL is software-written.
REQ-013 SHALL, on a tick with COUNT!=0 and COUNT not software-written, load COUNT-1 into COUNT.
REQ-014 SHALL, on a tick with COUNT==0 (expiry), set STATUS.EXP to 1.
REQ-015 SHALL, on expiry with AR=1, load LOAD into COUNT; with AR=0 it SHALL hold COUNT at 0 and clear CTRL.EN.
REQ-016 SHALL, when COUNT is software-written in a tick cycle, store the software value and skip the decrement and expiry for that tick.
REQ-017 SHALL, when a software write to CTRL coincides with an expiry that has AR=0, give the software CTRL value priority, so the EN bit written by software is kept.
REQ-018 SHALL clear STATUS.EXP on a software write of EXP=0 while EXP=1, except that a simultaneous expiry sets it and the set wins.
REQ-019 SHALL, with PRESC=0, tick every enabled cycle; a COUNT of N with AR=0 then sets EXP N+1 cycles after enable.
REQ-020 SHALL make a LOAD written in a given cycle visible to a reload occurring in the same cycle.
REQ-021 SHALL make mem_rd and irq reflect any update one cycle after the causing edge, and SHALL never place a combinational path from mem_wd to mem_rd.

Reset
REQ-022 SHALL, while rst_n=0, asynchronously force all four words, the prescale counter and irq to 0.
REQ-023 SHALL abandon a countdown in progress when rst_n is asserted, with no expiry generated.
REQ-024 SHALL resume updates at the first rising clk edge after rst_n deasserts.

Verification
REQ-025 SHALL pass the one-shot scenario: COUNT=3, CTRL=0x1 -> COUNT reads 2,1,0 on successive cycles; next cycle EXP=1, EN=0, COUNT=0, irq=0.
REQ-026 SHALL pass the auto-reload scenario: LOAD=2, COUNT=0, CTRL=0x7 -> EXP=1 and irq=1 after one cycle, COUNT=2, then 1,0,2 repeating, EN stays 1.
REQ-027 SHALL pass the prescale scenario: PRESC=3, COUNT=5, EN=1 -> COUNT decrements once every 4 cycles; 5 then 4 after 4 cycles.
REQ-028 SHALL pass the collision scenario: a write of COUNT=0x100 on a tick cycle -> COUNT=0x100 with no decrement; a write of EXP=0 coinciding with expiry -> EXP=1.
REQ-029 SHALL pass the reset scenario: rst_n pulsed low mid-countdown without a clk edge -> mem_rd=0 and irq=0 immediately; no EXP after release.
REQ-030 SHALL pass the reserved-bit scenario: write CTRL=0xFFFFFFFF -> CTRL reads 0x0000FF07 and STATUS[31:1] reads 0.
